// File: rtl/pipe_issue_ctrl.sv
// Fetch/issue sequencer and RAW hazard interlock for the 5-stage SCPU pipeline.
// Tracks destinations of instructions in EXE/DM/WB and stalls ID until no older producer remains.
module pipe_issue_ctrl #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] END_ADDR = 8'hFF,
  parameter int                DEPTH    = 3,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       id_ins,
  output logic [ADDR_W-1:0] ins_index,
  output logic              ifid_we,
  output logic              id_bubble,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              id_v_q, id_v_d;
  logic [DEPTH-1:0]  sb_v_q, sb_v_d;
  logic [1:0]        sb_rd_q [DEPTH];
  logic [1:0]        sb_rd_d [DEPTH];
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [3:0] op_s;
  logic [1:0] ra_s, rb_s;
  logic       op_alu_s, op_halt_s, op_reads_s;
  logic       match_s, hz_s, issue_s, fetch_ok_s, active_s, restart_s;
  logic       unused_s;

  assign op_s       = id_ins[15:12];
  assign ra_s       = id_ins[11:10];
  assign rb_s       = id_ins[9:8];
  assign unused_s   = ^id_ins[7:0];
  assign op_alu_s   = (op_s >= 4'h1) && (op_s <= 4'h7);
  assign op_halt_s  = (op_s == 4'hF);
  assign op_reads_s = (op_s != 4'h0) && !op_halt_s;
  assign active_s   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign restart_s  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Any valid in-flight destination matching a source operand of the ID instruction.
  always_comb begin
    match_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_v_q[i] && ((sb_rd_q[i] == ra_s) || (sb_rd_q[i] == rb_s))) begin
        match_s = 1'b1;
      end else begin
        match_s = match_s;
      end
    end
  end

  assign hz_s       = id_v_q && op_reads_s && match_s;
  assign issue_s    = id_v_q && !hz_s && op_reads_s;
  assign fetch_ok_s = !hz_s && !(id_v_q && op_halt_s) && (pc_q != END_ADDR);
  assign id_bubble  = !issue_s;
  assign ins_index  = pc_q;
  assign stall_cnt  = stall_cnt_q;

  // State, PC, ID-valid, scoreboard and stall counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      id_v_q      <= 1'b0;
      sb_v_q      <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sb_rd_q[i] <= 2'd0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_v_q      <= id_v_d;
      sb_v_q      <= sb_v_d;
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        sb_rd_q[i] <= sb_rd_d[i];
      end
    end
  end

  // Next-state logic; DRAIN ends once ID and the scoreboard will both be empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if ((id_v_q && op_halt_s) || (pc_q == END_ADDR)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (!id_v_d && (sb_v_d == '0)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    ifid_we = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_RUN: begin
        ifid_we = fetch_ok_s;
        busy    = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ifid_we = 1'b0;
    endcase
  end

  // PC, ID-valid and stall counter updates. NOP and HALT are consumed without entering EXE.
  always_comb begin
    pc_d        = pc_q;
    id_v_d      = id_v_q;
    stall_cnt_d = stall_cnt_q;
    if (restart_s) begin
      pc_d        = '0;
      stall_cnt_d = '0;
    end else if (ifid_we) begin
      pc_d = pc_q + ADDR_W'(1);
    end else begin
      pc_d = pc_q;
    end
    if (!active_s) begin
      id_v_d = 1'b0;
    end else if (ifid_we) begin
      id_v_d = 1'b1;
    end else if (id_v_q && !hz_s) begin
      id_v_d = 1'b0;
    end else begin
      id_v_d = id_v_q;
    end
    if (!restart_s && active_s && hz_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_d;
    end
  end

  // Scoreboard shifts every cycle; only issued ALU ops occupy a valid slot.
  always_comb begin
    sb_v_d     = '0;
    sb_v_d[0]  = issue_s && op_alu_s;
    sb_rd_d[0] = ra_s;
    for (int i = 1; i < DEPTH; i++) begin
      sb_v_d[i]  = sb_v_q[i-1];
      sb_rd_d[i] = sb_rd_q[i-1];
    end
  end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed bench for pipe_issue_ctrl: two instances (END_ADDR=4 / CNT_W=16 and END_ADDR=FF / CNT_W=2)
// with a behavioural instruction memory and IF/ID register each.
module tb_pipe_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [15:0] id_ins_a, id_ins_b;
  logic [7:0]  idx_a, idx_b;
  logic        we_a, we_b, bub_a, bub_b, busy_a, busy_b, done_a, done_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  logic [15:0] imem_a [256];
  logic [15:0] imem_b [256];
  int          n_run  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  pipe_issue_ctrl #(.ADDR_W(8), .END_ADDR(8'h04), .DEPTH(3), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .id_ins(id_ins_a), .ins_index(idx_a),
    .ifid_we(we_a), .id_bubble(bub_a), .busy(busy_a), .done(done_a), .stall_cnt(cnt_a)
  );

  pipe_issue_ctrl #(.ADDR_W(8), .END_ADDR(8'hFF), .DEPTH(3), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .id_ins(id_ins_b), .ins_index(idx_b),
    .ifid_we(we_b), .id_bubble(bub_b), .busy(busy_b), .done(done_b), .stall_cnt(cnt_b)
  );

  // IF/ID registers fed from the instruction memories.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ins_a <= 16'h0000;
      id_ins_b <= 16'h0000;
    end else begin
      if (we_a) id_ins_a <= imem_a[idx_a];
      if (we_b) id_ins_b <= imem_b[idx_b];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] idx, input logic we, input logic bub);
    chk({tag, ".idx"}, 32'(idx_a), 32'(idx));
    chk({tag, ".we"},  32'(we_a),  32'(we));
    chk({tag, ".bub"}, 32'(bub_a), 32'(bub));
  endtask

  task automatic wait_done(input bit sel, input int budget, input string tag);
    int k = 0;
    while (!(sel ? done_b : done_a) && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(sel ? done_b : done_a), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 256; i++) begin
      imem_a[i] = 16'h0000;
      imem_b[i] = 16'h0000;
    end
    tick(); tick();
    chk_a("rst", 8'd0, 1'b0, 1'b1);
    chk("rst.busy_a", 32'(busy_a), 32'd0);
    chk("rst.done_a", 32'(done_a), 32'd0);
    chk("rst.cnt_a",  32'(cnt_a),  32'd0);
    chk("rst.idx_b",  32'(idx_b),  32'd0);
    chk("rst.bub_b",  32'(bub_b),  32'd1);
    rst_n = 1'b1;
    tick();

    // T1: four independent instructions, END_ADDR=4
    imem_a[0] = 16'h1000; imem_a[1] = 16'h2500; imem_a[2] = 16'h3A00; imem_a[3] = 16'h4F00;
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_a("t1.fetch", 8'(i), 1'b1, (i == 0));
      chk("t1.busy", 32'(busy_a), 32'd1);
      tick();
    end
    chk_a("t1.last", 8'd4, 1'b0, 1'b0);
    tick();
    for (int j = 1; j < 4; j++) begin
      chk("t1.drain.done", 32'(done_a), 32'd0);
      chk("t1.drain.busy", 32'(busy_a), 32'd1);
      chk("t1.drain.bub",  32'(bub_a),  32'd1);
      tick();
    end
    chk("t1.done", 32'(done_a), 32'd1);
    chk("t1.busy_end", 32'(busy_a), 32'd0);
    chk("t1.cnt", 32'(cnt_a), 32'd0);

    // T2: consumer directly behind producer stalls 3 cycles
    imem_a[0] = 16'h1400; imem_a[1] = 16'h2900; imem_a[2] = 16'h3F00; imem_a[3] = 16'h8000;
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk_a("t2.r0", 8'd0, 1'b1, 1'b1);
    chk("t2.r0.cnt", 32'(cnt_a), 32'd0);
    tick();
    chk_a("t2.r1", 8'd1, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk_a("t2.stall", 8'd2, 1'b0, 1'b1);
      chk("t2.stall.cnt", 32'(cnt_a), 32'(k));
      tick();
    end
    chk_a("t2.resume", 8'd2, 1'b1, 1'b0);
    chk("t2.resume.cnt", 32'(cnt_a), 32'd3);
    wait_done(1'b0, 20, "t2.done");
    chk("t2.cnt", 32'(cnt_a), 32'd3);

    // T3: consumer two slots behind producer (NOP between) stalls 2 cycles
    imem_a[0] = 16'h1800; imem_a[1] = 16'h0000; imem_a[2] = 16'h3800; imem_a[3] = 16'h8F00;
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk_a("t3.r0", 8'd0, 1'b1, 1'b1);
    tick();
    chk_a("t3.r1", 8'd1, 1'b1, 1'b0);
    tick();
    chk_a("t3.nop", 8'd2, 1'b1, 1'b1);
    tick();
    for (int k = 0; k < 2; k++) begin
      chk_a("t3.stall", 8'd3, 1'b0, 1'b1);
      tick();
    end
    chk_a("t3.resume", 8'd3, 1'b1, 1'b0);
    wait_done(1'b0, 20, "t3.done");
    chk("t3.cnt", 32'(cnt_a), 32'd2);

    // T5: reset asserted in the middle of the T2 stall
    imem_a[0] = 16'h1400; imem_a[1] = 16'h2900; imem_a[2] = 16'h3F00; imem_a[3] = 16'h8000;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); tick(); tick();
    chk("t5.pre.cnt", 32'(cnt_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_a("t5.rst", 8'd0, 1'b0, 1'b1);
    chk("t5.rst.busy", 32'(busy_a), 32'd0);
    chk("t5.rst.done", 32'(done_a), 32'd0);
    chk("t5.rst.cnt",  32'(cnt_a),  32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_a("t5.idle", 8'd0, 1'b0, 1'b1);
      chk("t5.idle.busy", 32'(busy_a), 32'd0);
    end

    // T4: HALT at addr2 on the END_ADDR=FF instance
    imem_b[0] = 16'h1000; imem_b[1] = 16'h2500; imem_b[2] = 16'hF000; imem_b[3] = 16'h3A00;
    start_b = 1'b1; tick(); start_b = 1'b0;
    chk("t4.r0.idx", 32'(idx_b), 32'd0);
    tick();
    chk("t4.r1.bub", 32'(bub_b), 32'd0);
    tick();
    chk("t4.r2.bub", 32'(bub_b), 32'd0);
    tick();
    chk("t4.halt.idx",  32'(idx_b),  32'd3);
    chk("t4.halt.we",   32'(we_b),   32'd0);
    chk("t4.halt.bub",  32'(bub_b),  32'd1);
    chk("t4.halt.busy", 32'(busy_b), 32'd1);
    tick();
    chk("t4.d1.busy", 32'(busy_b), 32'd1);
    chk("t4.d1.bub",  32'(bub_b),  32'd1);
    chk("t4.d1.we",   32'(we_b),   32'd0);
    tick();
    chk("t4.d2.busy", 32'(busy_b), 32'd1);
    chk("t4.d2.idx",  32'(idx_b),  32'd3);
    tick();
    chk("t4.done", 32'(done_b), 32'd1);
    chk("t4.busy", 32'(busy_b), 32'd0);
    chk("t4.bub",  32'(bub_b),  32'd1);
    chk("t4.cnt",  32'(cnt_b),  32'd0);

    // T6: four dependent pairs saturate the 2-bit counter; start ignored in RUN, honoured in DONE
    for (int j = 0; j < 4; j++) begin
      imem_b[2*j]   = 16'h1400;
      imem_b[2*j+1] = 16'h2D00;
    end
    imem_b[8] = 16'hF000;
    start_b = 1'b1; tick(); start_b = 1'b0;
    chk("t6.r0.idx", 32'(idx_b), 32'd0);
    tick();
    start_b = 1'b1; tick(); start_b = 1'b0;
    chk("t6.ign.idx",  32'(idx_b),  32'd2);
    chk("t6.ign.busy", 32'(busy_b), 32'd1);
    wait_done(1'b1, 100, "t6.done");
    chk("t6.sat", 32'(cnt_b), 32'd3);
    start_b = 1'b1; tick(); start_b = 1'b0;
    chk("t6.re.idx",  32'(idx_b),  32'd0);
    chk("t6.re.we",   32'(we_b),   32'd1);
    chk("t6.re.cnt",  32'(cnt_b),  32'd0);
    chk("t6.re.busy", 32'(busy_b), 32'd1);
    wait_done(1'b1, 100, "t6.done2");
    chk("t6.sat2", 32'(cnt_b), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
